shift_sched: RTL and testbench

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_sched.sv | 78 +++++++
 tb/tb_shift_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler feeding a serial right-shifter, one job at a time
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req0/data0/amt0       requester 0 job: request (held until gnt0), 5-bit operand, shift amount
//   req1/data1/amt1       requester 1 job: same as requester 0
//   gnt0, gnt1            one-cycle pulse after a job is accepted
//   busy                  high on cycles following a shift step
//   done                  one-cycle pulse when y holds a new result
//   owner                 requester index of the result on y
//   y                     operand logically right-shifted by min(amt, 5)
module shift_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [4:0] data0,
    input  logic [2:0] amt0,
    input  logic       req1,
    input  logic [4:0] data1,
    input  logic [2:0] amt1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       owner,
    output logic [4:0] y
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t     state;
    logic [4:0] sr;
    logic [2:0] cnt;
    logic       job_own;
    logic       pri;
    logic       win;
    logic [2:0] amt_w;
    // pri names the requester that wins a tie: the one not served last
    assign win   = req1 & (~req0 | pri);
    assign amt_w = win ? amt1 : amt0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            job_own <= 1'b0;
            pri     <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            owner   <= 1'b0;
            y       <= '0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            if (state == IDLE) begin
                if (req0 | req1) begin
                    sr      <= win ? data1 : data0;
                    cnt     <= amt_w > 3'd5 ? 3'd5 : amt_w;
                    job_own <= win;
                    pri     <= ~win;
                    gnt0    <= ~win;
                    gnt1    <= win;
                    state   <= SHIFT;
                end
            end else if (cnt != 3'd0) begin
                sr   <= {1'b0, sr[4:1]};
                cnt  <= cnt - 3'd1;
                busy <= 1'b1;
            end else begin
                y     <= sr;
                owner <= job_own;
                done  <= 1'b1;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed literal checks plus randomized traffic against an event-time model
module tb_shift_sched;
    logic       clk = 1'b0, rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [4:0] data0 = '0, data1 = '0;
    logic [2:0] amt0 = '0, amt1 = '0;
    logic       gnt0, gnt1, busy, done, owner;
    logic [4:0] y;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    shift_sched dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .amt0(amt0),
        .req1(req1), .data1(data1), .amt1(amt1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .owner(owner), .y(y)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each job is described by its acceptance edge and effective amount;
    // every output follows from edge numbers alone.
    int         ecyc = 0, free_at = 0, acc_at = -100, done_at = -100, eff_n = 0, a_sel;
    bit         last = 1'b1, jown = 1'b0, w;
    bit         mg0 = 0, mg1 = 0, mbusy = 0, mdone = 0, mown = 0;
    logic [4:0] my = '0, jres = '0, d_sel;

    always @(posedge clk) begin
        ecyc++;
        if (rst) begin
            free_at = ecyc + 1;
            acc_at  = -100;
            done_at = -100;
            last    = 1'b1;
            my      = '0;
            mown    = 1'b0;
        end else begin
            if (ecyc >= free_at && (req0 || req1)) begin
                w       = (req0 && req1) ? !last : req1;
                a_sel   = w ? int'(amt1) : int'(amt0);
                d_sel   = w ? data1 : data0;
                eff_n   = a_sel > 5 ? 5 : a_sel;
                jres    = d_sel >> a_sel;
                jown    = w;
                last    = w;
                acc_at  = ecyc;
                done_at = ecyc + eff_n + 1;
                free_at = done_at + 1;
            end
            if (ecyc == done_at) begin
                my   = jres;
                mown = jown;
            end
        end
        mg0   = (ecyc == acc_at) && !jown;
        mg1   = (ecyc == acc_at) && jown;
        mbusy = (ecyc > acc_at) && (ecyc <= acc_at + eff_n);
        mdone = (ecyc == done_at);
    end

    always @(negedge clk) begin
        if (ecyc > 0) begin
            check("gnt0", gnt0, mg0);
            check("gnt1", gnt1, mg1);
            check("busy", busy, mbusy);
            check("done", done, mdone);
            check("y", y, my);
            check("owner", owner, mown);
        end
    end

    task automatic job(input bit r, input logic [4:0] d, input logic [2:0] a,
                       input logic [4:0] ey, input int elat);
        int n = 0;
        if (r) begin req1 = 1'b1; data1 = d; amt1 = a; end
        else   begin req0 = 1'b1; data0 = d; amt0 = a; end
        do begin
            @(negedge clk);
            n++;
            if (gnt0) begin req0 = 1'b0; data0 = ~d; amt0 = 3'd0; end
            if (gnt1) begin req1 = 1'b0; data1 = ~d; amt1 = 3'd0; end
        end while (!done && n < 20);
        check("job_latency", n, elat);
        check("job_y", y, ey);
        check("job_owner", owner, r);
    endtask

    initial begin
        int k, last_done, gcount, seen;
        repeat (2) @(negedge clk);
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt", gnt0 | gnt1, 0);
        rst = 1'b0;
        req0 = 1'b1; data0 = 5'b10110; amt0 = 3'd1;
        @(negedge clk);
        check("e0_gnt0", gnt0, 1);
        req0 = 1'b0; data0 = 5'b00000;
        @(negedge clk);
        check("e1_busy", busy, 1);
        @(negedge clk);
        check("e2_done", done, 1);
        check("e2_y", y, 5'b01011);
        check("e2_owner", owner, 0);
        job(1'b1, 5'b01000, 3'd3, 5'b00001, 5);
        job(1'b0, 5'b10011, 3'd0, 5'b10011, 2);
        job(1'b0, 5'b11111, 3'd7, 5'b00000, 7);
        job(1'b1, 5'b11111, 3'd6, 5'b00000, 7);
        job(1'b0, 5'b11010, 3'd5, 5'b00000, 7);
        job(1'b1, 5'b11010, 3'd2, 5'b00110, 4);
        // both requesters held high straight out of reset
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        data0 = 5'b00110; data1 = 5'b11000; amt0 = 3'd1; amt1 = 3'd1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0; last_done = -10; gcount = 0;
        while (gcount < 3 && k < 40) begin
            @(negedge clk);
            k++;
            if (done) last_done = k;
            if (gnt0 || gnt1) begin
                check("rr_winner", gnt1, gcount == 1);
                if (gcount > 0) check("rr_back_to_back", k, last_done + 1);
                gcount++;
            end
        end
        check("rr_grants", gcount, 3);
        // reset in the middle of a shift
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk);
        req0 = 1'b1; data0 = 5'b11111; amt0 = 3'd5;
        @(negedge clk);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_y", y, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (gnt0) req0 = $urandom_range(0, 3) == 0;
            else if (!req0) req0 = $urandom_range(0, 2) == 0;
            if (gnt1) req1 = $urandom_range(0, 3) == 0;
            else if (!req1) req1 = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 1) == 1) begin data0 = 5'($urandom); amt0 = 3'($urandom); end
            if ($urandom_range(0, 1) == 1) begin data1 = 5'($urandom); amt1 = 3'($urandom); end
            rst = $urandom_range(0, 299) == 0;
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
